// File: rtl/intra_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intra_pkg: shared types and clip helper for 4x4 luma intra reconstruction   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package intra_pkg;

   localparam int DEF_BIT_DEPTH = 8;
   localparam int DEF_RES_W     = 10;
   localparam int CLIP_W        = 18;

   typedef enum logic [3:0] {
      INTRA4_V  = 4'd0,
      INTRA4_H  = 4'd1,
      INTRA4_DC = 4'd2
   } intra_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRED  = 3'd1,
      ST_RECON = 3'd2,
      ST_ERR   = 3'd3,
      ST_DONE  = 3'd4
   } recon_state_e;

   // Saturates a signed sum into 0..2^bit_depth-1.
   function automatic logic [15:0] clip_pix(input logic signed [CLIP_W-1:0] val,
                                            input int bit_depth);
      logic signed [CLIP_W-1:0] max_val;
      max_val = CLIP_W'((1 << bit_depth) - 1);
      if (val[CLIP_W-1])
         clip_pix = '0;
      else if (val > max_val)
         clip_pix = 16'(max_val);
      else
         clip_pix = 16'(val);
   endfunction

endpackage
`default_nettype wire

// File: rtl/intra4x4_pred.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intra4x4_pred: combinational 4x4 luma predictor (V / H / DC)               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module intra4x4_pred
   import intra_pkg::*;
#(
   parameter int BIT_DEPTH = DEF_BIT_DEPTH
) (
   input  logic [3:0]             mode,
   input  logic [4*BIT_DEPTH-1:0] top,
   input  logic [4*BIT_DEPTH-1:0] left,
   input  logic                   top_avail,
   input  logic                   left_avail,
   input  logic [1:0]             x,
   input  logic [1:0]             y,
   input  logic [BIT_DEPTH-1:0]   dc_reg,
   output logic [BIT_DEPTH-1:0]   pred,
   output logic [BIT_DEPTH-1:0]   dc_val
);

   localparam int SUM_W = BIT_DEPTH + 3;

   logic [SUM_W-1:0] w_sum_top;
   logic [SUM_W-1:0] w_sum_left;

   always_comb begin
      w_sum_top  = '0;
      w_sum_left = '0;
      for (int k = 0; k < 4; k++) begin
         w_sum_top  = w_sum_top  + SUM_W'(top[k*BIT_DEPTH +: BIT_DEPTH]);
         w_sum_left = w_sum_left + SUM_W'(left[k*BIT_DEPTH +: BIT_DEPTH]);
      end
      if (top_avail && left_avail)
         dc_val = BIT_DEPTH'((w_sum_top + w_sum_left + SUM_W'(4)) >> 3);
      else if (top_avail)
         dc_val = BIT_DEPTH'((w_sum_top + SUM_W'(2)) >> 2);
      else if (left_avail)
         dc_val = BIT_DEPTH'((w_sum_left + SUM_W'(2)) >> 2);
      else
         dc_val = BIT_DEPTH'(SUM_W'(1) << (BIT_DEPTH - 1));
   end

   // DC uses the value frozen during PRED so the sums are off the pixel path.
   always_comb begin
      pred = dc_reg;
      case (mode)
         INTRA4_V: pred = top[int'(x)*BIT_DEPTH +: BIT_DEPTH];
         INTRA4_H: pred = left[int'(y)*BIT_DEPTH +: BIT_DEPTH];
         default:  pred = dc_reg;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/decoder_intra4x4_recon.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decoder_intra4x4_recon: rebuilds a 4x4 luma intra block from pred+residual |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module decoder_intra4x4_recon
   import intra_pkg::*;
#(
   parameter int BIT_DEPTH = DEF_BIT_DEPTH,
   parameter int RES_W     = DEF_RES_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [3:0]             mode,
   input  logic [4*BIT_DEPTH-1:0] top,
   input  logic [4*BIT_DEPTH-1:0] left,
   input  logic                   top_avail,
   input  logic                   left_avail,
   output logic                   busy,
   input  logic                   res_valid,
   input  logic [RES_W-1:0]       res_data,
   output logic                   res_ready,
   output logic                   pix_valid,
   output logic [BIT_DEPTH-1:0]   pix_data,
   output logic [1:0]             pix_x,
   output logic [1:0]             pix_y,
   output logic                   done,
   output logic                   mode_err
);

   recon_state_e           r_state;
   logic [3:0]             r_mode;
   logic [4*BIT_DEPTH-1:0] r_top;
   logic [4*BIT_DEPTH-1:0] r_left;
   logic                   r_top_avail;
   logic                   r_left_avail;
   logic [BIT_DEPTH-1:0]   r_dc;
   logic [3:0]             r_cnt;
   logic                   r_pix_valid;
   logic [BIT_DEPTH-1:0]   r_pix_data;
   logic [1:0]             r_pix_x;
   logic [1:0]             r_pix_y;
   logic                   r_done;
   logic                   r_mode_err;

   logic [BIT_DEPTH-1:0]   w_pred;
   logic [BIT_DEPTH-1:0]   w_dc_val;
   logic signed [RES_W:0]  w_sum;
   logic                   w_hs;
   logic                   w_mode_bad;

   intra4x4_pred #(.BIT_DEPTH(BIT_DEPTH)) u_pred (
      .mode       (r_mode),
      .top        (r_top),
      .left       (r_left),
      .top_avail  (r_top_avail),
      .left_avail (r_left_avail),
      .x          (r_cnt[1:0]),
      .y          (r_cnt[3:2]),
      .dc_reg     (r_dc),
      .pred       (w_pred),
      .dc_val     (w_dc_val)
   );

   assign w_hs       = res_valid && (r_state == ST_RECON);
   assign w_mode_bad = (r_mode > INTRA4_DC) ||
                       ((r_mode == INTRA4_V) && !r_top_avail) ||
                       ((r_mode == INTRA4_H) && !r_left_avail);
   assign w_sum      = $signed({{(RES_W+1-BIT_DEPTH){1'b0}}, w_pred}) +
                       $signed({res_data[RES_W-1], res_data});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_mode       <= '0;
         r_top        <= '0;
         r_left       <= '0;
         r_top_avail  <= 1'b0;
         r_left_avail <= 1'b0;
         r_dc         <= '0;
         r_cnt        <= '0;
         r_pix_valid  <= 1'b0;
         r_pix_data   <= '0;
         r_pix_x      <= '0;
         r_pix_y      <= '0;
         r_done       <= 1'b0;
         r_mode_err   <= 1'b0;
      end else begin
         r_pix_valid <= w_hs;
         r_done      <= 1'b0;
         r_mode_err  <= 1'b0;
         if (w_hs) begin
            r_pix_data <= BIT_DEPTH'(clip_pix(CLIP_W'(w_sum), BIT_DEPTH));
            r_pix_x    <= r_cnt[1:0];
            r_pix_y    <= r_cnt[3:2];
            r_cnt      <= r_cnt + 4'd1;
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_mode       <= mode;
                  r_top        <= top;
                  r_left       <= left;
                  r_top_avail  <= top_avail;
                  r_left_avail <= left_avail;
                  r_cnt        <= '0;
                  r_state      <= ST_PRED;
               end
            end
            ST_PRED: begin
               r_dc <= w_dc_val;
               if (w_mode_bad) begin
                  r_state    <= ST_ERR;
                  r_done     <= 1'b1;
                  r_mode_err <= 1'b1;
               end else begin
                  r_state <= ST_RECON;
               end
            end
            // Leaving RECON on the last handshake drops res_ready with the final pixel.
            ST_RECON: begin
               if (w_hs && (r_cnt == 4'd15)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_ERR:  r_state <= ST_IDLE;
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign res_ready = (r_state == ST_RECON);
   assign pix_valid = r_pix_valid;
   assign pix_data  = r_pix_data;
   assign pix_x     = r_pix_x;
   assign pix_y     = r_pix_y;
   assign done      = r_done;
   assign mode_err  = r_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_decoder_intra4x4_recon.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decoder_intra4x4_recon: scoreboard bench with reference predictor model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_decoder_intra4x4_recon;

   localparam int BD = 8;
   localparam int RW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    mode = '0;
   logic [4*BD-1:0] top = '0;
   logic [4*BD-1:0] left = '0;
   logic          top_avail = 1'b0;
   logic          left_avail = 1'b0;
   logic          res_valid = 1'b0;
   logic [RW-1:0] res_data = '0;
   logic          busy, res_ready, pix_valid, done, mode_err;
   logic [BD-1:0] pix_data;
   logic [1:0]    pix_x, pix_y;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   typedef struct {int d; int x; int y;} exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   decoder_intra4x4_recon #(.BIT_DEPTH(BD), .RES_W(RW)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .top(top), .left(left),
      .top_avail(top_avail), .left_avail(left_avail), .busy(busy),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
      .done(done), .mode_err(mode_err)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int clip(input int v);
      if (v < 0) return 0;
      if (v > (1 << BD) - 1) return (1 << BD) - 1;
      return v;
   endfunction

   function automatic int model_pred(input int m, input int t[4], input int l[4],
                                     input bit ta, input bit la, input int x, input int y);
      int st, sl;
      if (m == 0) return t[x];
      if (m == 1) return l[y];
      st = t[0] + t[1] + t[2] + t[3];
      sl = l[0] + l[1] + l[2] + l[3];
      if (ta && la) return (st + sl + 4) / 8;
      if (ta) return (st + 2) / 4;
      if (la) return (sl + 2) / 4;
      return 1 << (BD - 1);
   endfunction

   task automatic check_zero(input string name);
      check(name, int'({busy, res_ready, pix_valid, done, mode_err, pix_data, pix_x, pix_y}), 0);
   endtask

   // Monitor: pops the scoreboard on every presented pixel.
   always @(negedge clk) begin
      exp_t e;
      if (reset && pix_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pixel", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("pix_data", int'(pix_data), e.d);
            check("pix_x", int'(pix_x), e.x);
            check("pix_y", int'(pix_y), e.y);
         end
      end
      if (reset && done) begin
         done_cnt++;
         if (!mode_err) begin
            check("done_with_pixel", int'(pix_valid), 1);
            check("done_queue_empty", exp_q.size(), 0);
         end
      end
   end

   // gap: 0 none, 1 pattern 1,0,0,1, 2 random. stop_after<16 resets mid-block.
   task automatic run_block(input int m, input int t[4], input int l[4], input bit ta,
                            input bit la, input int res[16], input int gap,
                            input bit busy_start, input int stop_after);
      bit err;
      bit v;
      int i, c, d0;
      err = (m > 2) || (m == 0 && !ta) || (m == 1 && !la);
      i = 0;
      c = 0;
      @(posedge clk); #1;
      mode = 4'(m);
      for (int k = 0; k < 4; k++) begin
         top[k*BD +: BD]  = BD'(t[k]);
         left[k*BD +: BD] = BD'(l[k]);
      end
      top_avail  = ta;
      left_avail = la;
      start      = 1'b1;
      if (!err)
         for (int k = 0; k < 16; k++)
            exp_q.push_back('{clip(model_pred(m, t, l, ta, la, k % 4, k / 4) + res[k]), k % 4, k / 4});
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b0;
      if (err) begin
         res_valid = 1'b1;
         @(negedge clk);
         check("pred_busy", int'(busy), 1);
         check("pred_no_ready", int'(res_ready), 0);
         @(negedge clk);
         check("err_done", int'(done), 1);
         check("err_mode_err", int'(mode_err), 1);
         check("err_no_ready", int'(res_ready), 0);
         @(negedge clk);
         check("err_idle", int'(busy), 0);
         check("err_done_cleared", int'(done), 0);
         res_valid = 1'b0;
         check("err_done_once", done_cnt - d0, 1);
      end else begin
         while (i < stop_after && c < 400) begin
            if (gap == 0) v = 1'b1;
            else if (gap == 1) v = (c % 4 == 0) || (c % 4 == 3);
            else v = ($urandom_range(0, 2) != 0);
            res_valid = v;
            res_data  = RW'(res[i]);
            if (busy_start && c == 6) begin
               start = 1'b1;
               mode = 4'd0;
               top = '1;
               top_avail = 1'b1;
            end
            @(negedge clk);
            if (v && res_ready) i++;
            @(posedge clk); #1;
            start = 1'b0;
            c++;
         end
         res_valid = 1'b0;
         if (c >= 400) check("residual_timeout", 0, 1);
         if (stop_after < 16) begin
            @(negedge clk); #1;
            check("reset_partial_pixels", 16 - exp_q.size(), stop_after);
            reset = 1'b0;
            #1;
            check_zero("outputs_in_reset");
            exp_q.delete();
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk); #1;
            check_zero("outputs_after_release");
            check("reset_no_done", done_cnt - d0, 0);
         end else begin
            repeat (3) @(posedge clk);
            #1;
            check("done_once", done_cnt - d0, 1);
            check("back_idle", int'(busy), 0);
            check("queue_drained", exp_q.size(), 0);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int res[16];
      int t[4];
      int l[4];
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_outputs");
      reset = 1'b1;

      // T1 vertical
      foreach (res[k]) res[k] = 0;
      run_block(0, '{10, 20, 30, 40}, '{0, 0, 0, 0}, 1, 0, res, 0, 0, 16);
      // T2 DC both, then DC neither
      foreach (res[k]) res[k] = 1;
      run_block(2, '{100, 100, 100, 100}, '{50, 50, 50, 50}, 1, 1, res, 0, 0, 16);
      foreach (res[k]) res[k] = 0;
      run_block(2, '{100, 100, 100, 100}, '{50, 50, 50, 50}, 0, 0, res, 0, 0, 16);
      // T3 clip
      foreach (res[k]) res[k] = (k % 4 == 0) ? 20 : (k % 4 == 1) ? -300 : (k % 4 == 2) ? 5 : -250;
      run_block(0, '{250, 250, 250, 250}, '{0, 0, 0, 0}, 1, 0, res, 0, 0, 16);
      // T4 backpressure with a start pulse while busy
      foreach (res[k]) res[k] = k;
      run_block(1, '{0, 0, 0, 0}, '{1, 2, 3, 4}, 0, 1, res, 1, 1, 16);
      // T5 unsupported modes
      run_block(5, '{1, 2, 3, 4}, '{1, 2, 3, 4}, 1, 1, res, 0, 0, 16);
      run_block(0, '{1, 2, 3, 4}, '{1, 2, 3, 4}, 0, 1, res, 0, 0, 16);
      // T6 reset after the 7th pixel, then a clean block
      foreach (res[k]) res[k] = int'($urandom_range(0, 60)) - 30;
      run_block(0, '{60, 70, 80, 90}, '{0, 0, 0, 0}, 1, 0, res, 0, 0, 7);
      run_block(0, '{60, 70, 80, 90}, '{0, 0, 0, 0}, 1, 0, res, 0, 0, 16);
      // Randomised blocks
      for (int b = 0; b < 10; b++) begin
         foreach (t[k]) t[k] = int'($urandom_range(0, 255));
         foreach (l[k]) l[k] = int'($urandom_range(0, 255));
         foreach (res[k]) res[k] = int'($urandom_range(0, 1023)) - 512;
         run_block(int'($urandom_range(0, 3)), t, l, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), res, int'($urandom_range(0, 2)), 0, 16);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
